// File: rtl/memory_access_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_access_sequencer                                                    |
// | Single-outstanding fetch/load/store engine with lane steering and timeout. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module memory_access_sequencer #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_kind,
   input  logic [2:0]          req_size,
   input  logic [XLEN-1:0]     req_address,
   input  logic [XLEN-1:0]     req_store_data,
   output logic                memory_enable,
   output logic                memory_command,
   output logic [XLEN-1:0]     memory_address,
   output logic [XLEN-1:0]     memory_write_data,
   output logic [XLEN/8-1:0]   memory_byte_enable,
   input  logic                memory_ready,
   input  logic                memory_valid,
   input  logic [XLEN-1:0]     memory_read_data,
   output logic                resp_valid,
   output logic [XLEN-1:0]     resp_data,
   output logic                resp_exception,
   output logic [30:0]         resp_exception_cause,
   output logic                busy
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_RESPOND = 2'd3;

   localparam logic [1:0] K_FETCH = 2'd0;
   localparam logic [1:0] K_LOAD  = 2'd1;
   localparam logic [1:0] K_STORE = 2'd2;
   localparam logic [1:0] K_RSVD  = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [1:0]             kind_q, kind_d;
   logic [2:0]             size_q, size_d;
   logic [XLEN-1:0]        addr_q, addr_d;
   logic [XLEN-1:0]        sdata_q, sdata_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic [XLEN-1:0]        rdata_q, rdata_d;
   logic                   exc_q, exc_d;
   logic [30:0]            cause_q, cause_d;

   logic [2:0]       w_amask;
   logic             w_size_bad;
   logic             w_misaligned;
   logic             w_req_bad;
   logic [30:0]      w_req_cause;
   logic [OFFW-1:0]  w_off;
   logic [3:0]       w_nbytes;
   logic [6:0]       w_bits;
   logic [NB-1:0]    w_mask;
   logic [XLEN-1:0]  w_shift;
   logic             w_msb;
   logic             w_fill;
   logic [XLEN-1:0]  w_load;
   logic [XLEN-1:0]  w_done_data;
   logic [30:0]      w_tmo_cause;
   logic             w_complete;

   // Request legality is judged on the live request so illegal ones skip the bus.
   always_comb begin
      case (req_size[1:0])
         2'd0:    w_amask = 3'b000;
         2'd1:    w_amask = 3'b001;
         2'd2:    w_amask = 3'b011;
         default: w_amask = 3'b111;
      endcase
      w_misaligned = |(req_address[2:0] & w_amask);
      w_size_bad   = (req_size == 3'b111)
                   || ((XLEN == 32) && ((req_size == 3'b011) || (req_size == 3'b110)))
                   || ((req_kind == K_STORE) && req_size[2])
                   || ((req_kind == K_FETCH) && (req_size != 3'b010));
      w_req_bad   = 1'b1;
      w_req_cause = 31'd2;
      if (req_kind == K_RSVD || w_size_bad) begin
         w_req_cause = 31'd2;
      end else if (w_misaligned) begin
         case (req_kind)
            K_FETCH: w_req_cause = 31'd0;
            K_LOAD:  w_req_cause = 31'd4;
            default: w_req_cause = 31'd6;
         endcase
      end else begin
         w_req_bad   = 1'b0;
         w_req_cause = 31'd0;
      end
   end

   assign w_off    = addr_q[OFFW-1:0];
   assign w_nbytes = 4'd1 << size_q[1:0];
   assign w_bits   = {w_nbytes, 3'b000};
   assign w_mask   = NB'((16'd1 << w_nbytes) - 16'd1);
   assign w_shift  = memory_read_data >> {w_off, 3'b000};

   always_comb begin
      w_msb  = 1'b0;
      w_load = '0;
      for (int i = 0; i < XLEN; i++) begin
         if (i == int'(w_bits) - 1) w_msb = w_shift[i];
      end
      w_fill = w_msb & ~size_q[2];
      for (int i = 0; i < XLEN; i++) begin
         w_load[i] = (i < int'(w_bits)) ? w_shift[i] : w_fill;
      end
   end

   always_comb begin
      case (kind_q)
         K_FETCH: w_done_data = memory_read_data;
         K_LOAD:  w_done_data = w_load;
         default: w_done_data = '0;
      endcase
      case (kind_q)
         K_FETCH: w_tmo_cause = 31'd1;
         K_LOAD:  w_tmo_cause = 31'd5;
         default: w_tmo_cause = 31'd7;
      endcase
   end

   assign w_complete = memory_valid && ((state_q == S_WAIT) || memory_ready);

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      size_d  = size_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      timer_d = timer_q;
      rdata_d = rdata_q;
      exc_d   = exc_q;
      cause_d = cause_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               kind_d  = req_kind;
               size_d  = req_size;
               addr_d  = req_address;
               sdata_d = req_store_data;
               if (w_req_bad) begin
                  state_d = S_RESPOND;
                  exc_d   = 1'b1;
                  cause_d = w_req_cause;
                  rdata_d = '0;
               end else begin
                  state_d = S_ISSUE;
                  timer_d = '0;
               end
            end
         end
         S_ISSUE, S_WAIT: begin
            timer_d = timer_q + TIMER_WIDTH'(1);
            // Completion takes priority over a timeout landing in the same cycle.
            if (w_complete) begin
               state_d = S_RESPOND;
               exc_d   = 1'b0;
               cause_d = 31'd0;
               rdata_d = w_done_data;
            end else if (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_RESPOND;
               exc_d   = 1'b1;
               cause_d = w_tmo_cause;
               rdata_d = '0;
            end else if ((state_q == S_ISSUE) && memory_ready) begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         kind_q  <= K_FETCH;
         size_q  <= 3'b000;
         addr_q  <= '0;
         sdata_q <= '0;
         timer_q <= '0;
         rdata_q <= '0;
         exc_q   <= 1'b0;
         cause_q <= 31'd0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         timer_q <= timer_d;
         rdata_q <= rdata_d;
         exc_q   <= exc_d;
         cause_q <= cause_d;
      end
   end

   assign req_ready            = (state_q == S_IDLE);
   assign busy                 = (state_q != S_IDLE);
   assign memory_enable        = (state_q == S_ISSUE) && memory_ready;
   assign memory_command       = (kind_q == K_STORE);
   assign memory_address       = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
   assign memory_write_data    = sdata_q << {w_off, 3'b000};
   assign memory_byte_enable   = w_mask << w_off;
   assign resp_valid           = (state_q == S_RESPOND);
   assign resp_data            = rdata_q;
   assign resp_exception       = exc_q;
   assign resp_exception_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memory_access_sequencer                                                 |
// | Directed and randomized checks of the sequencer at XLEN 32 and 64.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_memory_access_sequencer;

   localparam int TMO = 16;

   typedef struct {
      logic        exc;
      logic [30:0] cause;
      logic [63:0] data;
      int          lat;
      bit          en_seen;
      logic [63:0] maddr;
      logic [7:0]  be;
      logic [63:0] wdata;
      logic        cmd;
   } obs_t;

   typedef struct {
      logic        exc;
      logic [30:0] cause;
      logic [63:0] data;
      logic [63:0] maddr;
      logic [7:0]  be;
      logic [63:0] wdata;
      logic        cmd;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sel64 = 1'b0;
   logic        req_valid = 1'b0;
   logic [1:0]  req_kind = 2'd0;
   logic [2:0]  req_size = 3'd0;
   logic [63:0] req_address = '0;
   logic [63:0] req_store_data = '0;
   logic        memory_ready = 1'b0;
   logic        memory_valid = 1'b0;
   logic [63:0] memory_read_data = '0;

   logic        r32_req_ready, r32_en, r32_cmd, r32_resp_valid, r32_exc, r32_busy;
   logic [31:0] r32_addr, r32_wdata, r32_data;
   logic [3:0]  r32_be;
   logic [30:0] r32_cause;
   logic        r64_req_ready, r64_en, r64_cmd, r64_resp_valid, r64_exc, r64_busy;
   logic [63:0] r64_addr, r64_wdata, r64_data;
   logic [7:0]  r64_be;
   logic [30:0] r64_cause;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   memory_access_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) u_dut32 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & ~sel64), .req_ready(r32_req_ready),
      .req_kind(req_kind), .req_size(req_size),
      .req_address(req_address[31:0]), .req_store_data(req_store_data[31:0]),
      .memory_enable(r32_en), .memory_command(r32_cmd),
      .memory_address(r32_addr), .memory_write_data(r32_wdata),
      .memory_byte_enable(r32_be),
      .memory_ready(memory_ready), .memory_valid(memory_valid),
      .memory_read_data(memory_read_data[31:0]),
      .resp_valid(r32_resp_valid), .resp_data(r32_data),
      .resp_exception(r32_exc), .resp_exception_cause(r32_cause),
      .busy(r32_busy)
   );

   memory_access_sequencer #(.XLEN(64), .TIMEOUT_CYCLES(TMO)) u_dut64 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & sel64), .req_ready(r64_req_ready),
      .req_kind(req_kind), .req_size(req_size),
      .req_address(req_address), .req_store_data(req_store_data),
      .memory_enable(r64_en), .memory_command(r64_cmd),
      .memory_address(r64_addr), .memory_write_data(r64_wdata),
      .memory_byte_enable(r64_be),
      .memory_ready(memory_ready), .memory_valid(memory_valid),
      .memory_read_data(memory_read_data),
      .resp_valid(r64_resp_valid), .resp_data(r64_data),
      .resp_exception(r64_exc), .resp_exception_cause(r64_cause),
      .busy(r64_busy)
   );

   // Observe whichever instance is currently selected.
   wire        w_req_ready  = sel64 ? r64_req_ready  : r32_req_ready;
   wire        w_en         = sel64 ? r64_en         : r32_en;
   wire        w_cmd        = sel64 ? r64_cmd        : r32_cmd;
   wire        w_resp_valid = sel64 ? r64_resp_valid : r32_resp_valid;
   wire        w_exc        = sel64 ? r64_exc        : r32_exc;
   wire        w_busy       = sel64 ? r64_busy       : r32_busy;
   wire [30:0] w_cause      = sel64 ? r64_cause      : r32_cause;
   wire [63:0] w_addr       = sel64 ? r64_addr       : {32'h0, r32_addr};
   wire [63:0] w_wdata      = sel64 ? r64_wdata      : {32'h0, r32_wdata};
   wire [63:0] w_data       = sel64 ? r64_data       : {32'h0, r32_data};
   wire [7:0]  w_be         = sel64 ? r64_be         : {4'h0, r32_be};

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: expected outcome of one request from the architectural rules.
   task automatic model(input bit is64, input logic [1:0] kind, input logic [2:0] size,
                        input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] rdata, output exp_t e);
      int          xb = is64 ? 8 : 4;
      int          nb = 1 << size[1:0];
      int          off = int'(addr[2:0]) % xb;
      logic [63:0] xm = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      logic [63:0] v, m;
      logic [15:0] be16;
      e.exc = 1'b1; e.cause = 31'd2; e.data = '0;
      e.maddr = '0; e.be = '0; e.wdata = '0; e.cmd = 1'b0;
      if (kind == 2'd3) begin
         e.cause = 31'd2;
      end else if (size == 3'd7 || (!is64 && (size == 3'd3 || size == 3'd6))
                   || (kind == 2'd2 && size[2]) || (kind == 2'd0 && size != 3'd2)) begin
         e.cause = 31'd2;
      end else if ((int'(addr[2:0]) % nb) != 0) begin
         e.cause = (kind == 2'd0) ? 31'd0 : (kind == 2'd1) ? 31'd4 : 31'd6;
      end else begin
         e.exc   = 1'b0;
         e.cause = 31'd0;
         e.maddr = addr & xm & ~64'(xb - 1);
         be16    = ((16'd1 << nb) - 16'd1) << off;
         e.be    = be16[7:0];
         e.wdata = ((sdata & xm) << (8 * off)) & xm;
         e.cmd   = (kind == 2'd2);
         if (kind == 2'd0) begin
            e.data = rdata & xm;
         end else if (kind == 2'd1) begin
            v = (rdata & xm) >> (8 * off);
            if (nb * 8 < 64) begin
               m = (64'd1 << (8 * nb)) - 64'd1;
               v = v & m;
               if (!size[2] && v[8 * nb - 1]) v = v | ~m;
            end
            e.data = v & xm;
         end
      end
   endtask

   // Drive one request and act as the bus: ready after rdy cycles, valid vld cycles after acceptance.
   task automatic run_req(input bit is64, input logic [1:0] kind, input logic [2:0] size,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] rdata, input int rdy, input int vld,
                          output obs_t o);
      bit acc = 0;
      int acc_k = 0;
      o.exc = 0; o.cause = 0; o.data = 0; o.lat = 0; o.en_seen = 0;
      o.maddr = 0; o.be = 0; o.wdata = 0; o.cmd = 0;
      @(negedge clk);
      sel64 = is64; req_valid = 1'b1; req_kind = kind; req_size = size;
      req_address = addr; req_store_data = sdata; memory_read_data = rdata;
      memory_ready = 1'b0; memory_valid = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (w_resp_valid) begin
            o.lat = k; o.exc = w_exc; o.cause = w_cause; o.data = w_data;
            break;
         end
         if (!acc) begin
            memory_ready = (k - 1 >= rdy);
            memory_valid = memory_ready && (vld == 0);
            #1;
            if (w_en) begin
               acc = 1; acc_k = k; o.en_seen = 1;
               o.maddr = w_addr; o.be = w_be; o.wdata = w_wdata; o.cmd = w_cmd;
            end
         end else begin
            memory_ready = 1'b0;
            memory_valid = (k - acc_k == vld);
         end
         @(negedge clk);
      end
      memory_ready = 1'b0;
      memory_valid = 1'b0;
      check_value("resp_seen", 64'(o.lat != 0), 64'd1);
      @(negedge clk);
      check_value("resp_pulse", 64'(w_resp_valid), 64'd0);
      check_value("ready_after", 64'(w_req_ready), 64'd1);
   endtask

   obs_t o;
   exp_t e;

   initial begin
      bit          is64;
      logic [1:0]  kind;
      logic [2:0]  size;
      logic [63:0] addr, sdata, rdata;
      int          rdy, vld;
      bit          saw;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_value("rst_req_ready", 64'(w_req_ready), 64'd1);
      check_value("rst_mem_en", 64'(w_en), 64'd0);
      check_value("rst_resp_valid", 64'(w_resp_valid), 64'd0);
      check_value("rst_exc", 64'(w_exc), 64'd0);
      check_value("rst_cause", 64'(w_cause), 64'd0);
      check_value("rst_data", w_data, 64'd0);
      check_value("rst_busy", 64'(w_busy), 64'd0);
      reset = 1'b1;

      run_req(0, 2'd1, 3'b000, 64'h103, 64'h0, 64'h8012_3456, 0, 1, o);
      check_value("lb_be", 64'(o.be), 64'h8);
      check_value("lb_addr", o.maddr, 64'h100);
      check_value("lb_data", o.data, 64'hFFFF_FF80);
      check_value("lb_exc", 64'(o.exc), 64'd0);

      run_req(0, 2'd2, 3'b001, 64'h202, 64'h0000_ABCD, 64'h0, 0, 1, o);
      check_value("sh_cmd", 64'(o.cmd), 64'd1);
      check_value("sh_be", 64'(o.be), 64'hC);
      check_value("sh_wdata", o.wdata, 64'hABCD_0000);
      check_value("sh_lat", 64'(o.lat), 64'd3);
      check_value("sh_data", o.data, 64'd0);

      run_req(0, 2'd1, 3'b010, 64'h101, 64'h0, 64'h0, 0, 0, o);
      check_value("lw_mis_en", 64'(o.en_seen), 64'd0);
      check_value("lw_mis_lat", 64'(o.lat), 64'd1);
      check_value("lw_mis_exc", 64'(o.exc), 64'd1);
      check_value("lw_mis_cause", 64'(o.cause), 64'd4);
      run_req(0, 2'd2, 3'b010, 64'h101, 64'h0, 64'h0, 0, 0, o);
      check_value("sw_mis_cause", 64'(o.cause), 64'd6);

      run_req(0, 2'd0, 3'b010, 64'h400, 64'h0, 64'h0, 1000, 0, o);
      check_value("ftmo_exc", 64'(o.exc), 64'd1);
      check_value("ftmo_cause", 64'(o.cause), 64'd1);
      check_value("ftmo_lat", 64'(o.lat), 64'(TMO + 1));
      check_value("ftmo_en", 64'(o.en_seen), 64'd0);
      // A stray completion arriving in IDLE must not raise a response.
      memory_valid = 1'b1;
      @(negedge clk);
      check_value("late_valid_resp", 64'(w_resp_valid), 64'd0);
      check_value("late_valid_idle", 64'(w_req_ready), 64'd1);
      memory_valid = 1'b0;

      run_req(0, 2'd1, 3'b010, 64'h40, 64'h0, 64'h0, 0, 1000, o);
      check_value("ltmo_cause", 64'(o.cause), 64'd5);
      check_value("ltmo_lat", 64'(o.lat), 64'(TMO + 1));

      run_req(0, 2'd1, 3'b101, 64'h2, 64'h0, 64'hF00D_0000, 0, 0, o);
      check_value("lhu_data", o.data, 64'h0000_F00D);
      check_value("lhu_lat", 64'(o.lat), 64'd2);

      run_req(1, 2'd1, 3'b011, 64'h8, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, 2, o);
      check_value("ld64_data", o.data, 64'hDEAD_BEEF_0123_4567);
      check_value("ld64_be", 64'(o.be), 64'hFF);
      check_value("ld64_addr", o.maddr, 64'h8);

      run_req(0, 2'd1, 3'b011, 64'h8, 64'h0, 64'h0, 0, 0, o);
      check_value("ld32_cause", 64'(o.cause), 64'd2);
      check_value("ld32_exc", 64'(o.exc), 64'd1);

      // Reset while waiting for read data aborts the access silently.
      @(negedge clk);
      sel64 = 1'b0; req_valid = 1'b1; req_kind = 2'd1; req_size = 3'b010;
      req_address = 64'h40;
      @(negedge clk);
      req_valid = 1'b0; memory_ready = 1'b1;
      @(negedge clk);
      memory_ready = 1'b0;
      check_value("rstw_busy", 64'(w_busy), 64'd1);
      reset = 1'b0;
      @(negedge clk);
      check_value("rstw_ready", 64'(w_req_ready), 64'd1);
      check_value("rstw_resp", 64'(w_resp_valid), 64'd0);
      check_value("rstw_en", 64'(w_en), 64'd0);
      reset = 1'b1; memory_valid = 1'b1;
      saw = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         memory_valid = 1'b0;
         if (w_resp_valid) saw = 1;
      end
      check_value("rstw_no_resp", 64'(saw), 64'd0);

      for (int it = 0; it < 80; it++) begin
         is64  = ($urandom_range(0, 1) == 1);
         kind  = 2'($urandom_range(0, 3));
         size  = 3'($urandom_range(0, 7));
         if (kind == 2'd0 && $urandom_range(0, 3) != 0) size = 3'b010;
         addr  = {32'($urandom), 32'($urandom)};
         if ($urandom_range(0, 1) == 1) addr[2:0] = 3'b000;
         sdata = {32'($urandom), 32'($urandom)};
         rdata = {32'($urandom), 32'($urandom)};
         rdy   = $urandom_range(0, 4);
         vld   = $urandom_range(0, 4);
         model(is64, kind, size, addr, sdata, rdata, e);
         run_req(is64, kind, size, addr, sdata, rdata, rdy, vld, o);
         check_value("rnd_exc", 64'(o.exc), 64'(e.exc));
         check_value("rnd_cause", 64'(o.cause), 64'(e.cause));
         check_value("rnd_data", o.data, e.data);
         check_value("rnd_en_seen", 64'(o.en_seen), 64'(!e.exc));
         check_value("rnd_lat", 64'(o.lat), e.exc ? 64'd1 : 64'(rdy + vld + 2));
         if (!e.exc) begin
            check_value("rnd_maddr", o.maddr, e.maddr);
            check_value("rnd_be", 64'(o.be), 64'(e.be));
            check_value("rnd_wdata", o.wdata, e.wdata);
            check_value("rnd_cmd", 64'(o.cmd), 64'(e.cmd));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
